instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The parameter DEPTH SHALL default to 256 and SHALL set the number of instruction-memory words; memAddr width SHALL be clog2(DEPTH).
REQ-002 The parameter BASE SHALL default to 0 and SHALL set the first word address written after reset or clear.
REQ-003 The port clk SHALL be an input of width 1 and SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 The port rstn SHALL be an input of width 1, SHALL be asynchronous and SHALL be active-low.
REQ-005 The port inValid SHALL be an input of width 1 and SHALL indicate that the instruction fields are valid.
REQ-006 The port inReady SHALL be an output of width 1 and SHALL indicate that the encoder accepts fields this cycle.
REQ-007 The port op SHALL be an input of width 3 with encoding 0 lw, 1 sw, 2 add, 3 addi, 4 beq, 5 jal; values 6 and 7 SHALL be illegal.
REQ-008 The ports rd, rs1 and rs2 SHALL each be inputs of width 5 and SHALL carry register numbers.
REQ-009 The port imme SHALL be an input of width 32 and SHALL be a signed immediate; beq and jal SHALL take it in halfword units, identical to the decoder's imme output.
REQ-010 The port memWe SHALL be an output of width 1 and SHALL be the instruction-memory write strobe.
REQ-011 The port memAddr SHALL be an output of width clog2(DEPTH) and SHALL be the word address.
REQ-012 The port memData SHALL be an output of width 32 and SHALL be the encoded instruction.
REQ-013 The port memReady SHALL be an input of width 1; a write SHALL complete on a cycle where memWe and memReady are both 1.
REQ-014 The port clr SHALL be an input of width 1 and SHALL be a synchronous clear of the error flag, the full flag and the address counter.
REQ-015 The port err SHALL be an output of width 1 and SHALL be a sticky error flag.
REQ-016 The port errCode SHALL be an output of width 2 with encoding 1 illegal op and 2 immediate out of range.
REQ-017 The port full SHALL be an output of width 1 and SHALL be set after the word at address DEPTH-1 is written.
REQ-018 The port count SHALL be an output of width clog2(DEPTH)+1 and SHALL hold the number of words written since reset or clear.

Function
REQ-019 The FSM SHALL have the states IDLE, CHECK, WRITE and FULL.
REQ-020 inReady SHALL be 1 only in IDLE with clr=0; an accept SHALL register op, rd, rs1, rs2 and imme and SHALL move to CHECK.
REQ-021 In CHECK the block SHALL range-check the immediate: lw, sw and addi within a signed 12-bit range [-2048, 2047]; beq within signed 12-bit halfwords [-2048, 2047]; jal within signed 20-bit halfwords [-524288, 524287]; add SHALL ignore imme.
REQ-022 An illegal op or an out-of-range immediate in CHECK SHALL set err, SHALL load errCode (illegal op takes priority), SHALL write nothing and SHALL return to IDLE.
REQ-023 A legal instruction in CHECK SHALL register memData and SHALL enter WRITE.
REQ-024 Encodings SHALL be fixed as follows:
- lw: imme[11:0], rs1, 010, rd, 0000011.
- sw: imme[11:5], rs2, rs1, 010, imme[4:0], 0100011.
- add: 0000000, rs2, rs1, 000, rd, 0110011.
- addi: imme[11:0], rs1, 000, rd, 0010011.
- beq (halfword h=imme): h[11], h[9:4], rs2, rs1, 000, h[3:0], h[10], 1100011.
- jal: h[19], h[9:0], h[10], h[18:11], rd, 1101111.
REQ-025 In WRITE, memWe SHALL hold 1 and memAddr/memData SHALL stay stable until memReady=1; on completion the address SHALL increment and count SHALL increment.
REQ-026 On completion at address DEPTH-1 the block SHALL set full and SHALL enter FULL; otherwise it SHALL enter IDLE. The address SHALL NOT wrap.
REQ-027 In FULL, inReady SHALL be 0 until clr.
REQ-028 Latency SHALL be 2 cycles from accept to the first cycle with memWe=1; with memReady tied to 1, throughput SHALL be one word per 3 cycles.
REQ-029 clr in IDLE, CHECK or FULL SHALL take effect on the next edge: err=0, errCode=0, full=0, count=0, address=BASE, state IDLE.
REQ-030 clr in WRITE SHALL first complete the pending write, then SHALL apply the clear, so no write is lost.
REQ-031 err set and clr in the same cycle SHALL resolve to clr.
REQ-032 err SHALL NOT block further accepts.

Reset
REQ-033 While rstn=0: state=IDLE, inReady=0, memWe=0, memAddr=BASE, memData=0, err=0, errCode=0, full=0, count=0; inReady SHALL rise on the first edge after release.
REQ-034 An rstn assertion mid-WRITE SHALL abort the write, with memWe=0 immediately and asynchronously.

Verification
REQ-035 Bench case: addi rd=1, rs1=0, imme=5 -> memData=0x00500093 at addr 0, count=1.
REQ-036 Bench case: beq rs1=1, rs2=2, imme=-2 (halfwords) -> memData=0xFE208EE3, and the decoder's imme output SHALL equal 0xFFFFFFFE.
REQ-037 Bench case: jal rd=1, imme=0x7FFFF -> written; imme=0x80000 -> err=1, errCode=2, no memWe.
REQ-038 Bench case: op=7 with imme=4096 -> errCode=1; then clr -> err=0, addr=BASE.
REQ-039 Bench case: DEPTH=4 with four legal writes -> full=1, inReady=0; a fifth inValid SHALL be ignored until clr.
REQ-040 Bench case: memReady held 0 for 5 cycles in WRITE -> memData stable, then one write; rstn pulsed mid-WRITE -> no write, count unchanged from reset value.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes one instruction per transaction (lw/sw/add/addi/beq/jal) into a 32-bit word
// and streams it into an instruction memory at consecutive word addresses.
module instr_encoder #(
  parameter int DEPTH = 256,
  parameter int BASE  = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [2:0]                 op,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [31:0]                imme,
  output logic                       memWe,
  output logic [$clog2(DEPTH)-1:0]   memAddr,
  output logic [31:0]                memData,
  input  logic                       memReady,
  input  logic                       clr,
  output logic                       err,
  output logic [1:0]                 errCode,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] BASE_A   = AW'(BASE);
  localparam logic [AW-1:0] LAST_A   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

  localparam logic [2:0] OP_LW   = 3'd0;
  localparam logic [2:0] OP_SW   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_ADDI = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_JAL  = 3'd5;

  localparam logic [1:0] CODE_ILLEGAL = 2'd1;
  localparam logic [1:0] CODE_RANGE   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WRITE = 2'd2,
    S_FULL  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          rdy_q, rdy_d;
  logic [2:0]    op_q, op_d;
  logic [4:0]    rd_q, rd_d;
  logic [4:0]    rs1_q, rs1_d;
  logic [4:0]    rs2_q, rs2_d;
  logic [31:0]   imm_q, imm_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          full_q, full_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          clrp_q, clrp_d;

  logic          accept;
  logic          illegal;
  logic          fits12;
  logic          fits20;
  logic          range_bad;
  logic          bad;
  logic          done;
  logic          done_clear;
  logic [31:0]   enc;

  assign accept     = inValid && inReady;
  assign illegal    = op_q[2] && op_q[1];
  assign fits12     = (&imm_q[31:11]) || (~|imm_q[31:11]);
  assign fits20     = (&imm_q[31:19]) || (~|imm_q[31:19]);
  assign bad        = illegal || range_bad;
  assign done       = (state_q == S_WRITE) && memReady;
  // A clear seen at any point during WRITE is honoured only once the write lands.
  assign done_clear = done && (clr || clrp_q);

  always_comb begin
    range_bad = 1'b0;
    case (op_q)
      OP_LW, OP_SW, OP_ADDI, OP_BEQ: range_bad = !fits12;
      OP_JAL:                        range_bad = !fits20;
      default:                       range_bad = 1'b0;
    endcase
  end

  // beq and jal take imm_q as a halfword offset, so bit 0 of the byte offset is implicit.
  always_comb begin
    enc = 32'h0000_0000;
    case (op_q)
      OP_LW:   enc = {imm_q[11:0], rs1_q, 3'b010, rd_q, 7'b0000011};
      OP_SW:   enc = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
      OP_ADD:  enc = {7'b0000000, rs2_q, rs1_q, 3'b000, rd_q, 7'b0110011};
      OP_ADDI: enc = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b0010011};
      OP_BEQ:  enc = {imm_q[11], imm_q[9:4], rs2_q, rs1_q, 3'b000, imm_q[3:0], imm_q[10], 7'b1100011};
      OP_JAL:  enc = {imm_q[19], imm_q[9:0], imm_q[10], imm_q[18:11], rd_q, 7'b1101111};
      default: enc = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      op_q    <= 3'd0;
      rd_q    <= 5'd0;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      imm_q   <= 32'h0000_0000;
      addr_q  <= BASE_A;
      data_q  <= 32'h0000_0000;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
      full_q  <= 1'b0;
      cnt_q   <= '0;
      clrp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      code_q  <= code_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
      clrp_q  <= clrp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!clr && accept) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (clr || bad) state_d = S_IDLE;
        else            state_d = S_WRITE;
      end
      S_WRITE: begin
        if (done) begin
          if (done_clear)              state_d = S_IDLE;
          else if (addr_q == LAST_A)   state_d = S_FULL;
          else                         state_d = S_IDLE;
        end
      end
      S_FULL: begin
        if (clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdy_d  = 1'b1;
    op_d   = op_q;
    rd_d   = rd_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    imm_d  = imm_q;
    addr_d = addr_q;
    data_d = data_q;
    err_d  = err_q;
    code_d = code_q;
    full_d = full_q;
    cnt_d  = cnt_q;
    clrp_d = clrp_q;

    if (accept) begin
      op_d  = op;
      rd_d  = rd;
      rs1_d = rs1;
      rs2_d = rs2;
      imm_d = imme;
    end

    if (state_q == S_CHECK && !clr) begin
      if (bad) begin
        err_d  = 1'b1;
        code_d = illegal ? CODE_ILLEGAL : CODE_RANGE;
      end else begin
        data_d = enc;
      end
    end

    if (state_q == S_WRITE) begin
      if (clr) clrp_d = 1'b1;
      if (done) begin
        clrp_d = 1'b0;
        cnt_d  = cnt_q + CNT_ONE;
        if (addr_q == LAST_A) full_d = 1'b1;
        else                  addr_d = addr_q + ADDR_ONE;
      end
    end

    if ((clr && state_q != S_WRITE) || done_clear) begin
      err_d  = 1'b0;
      code_d = 2'd0;
      full_d = 1'b0;
      cnt_d  = '0;
      addr_d = BASE_A;
    end
  end

  always_comb begin
    inReady = rdy_q && (state_q == S_IDLE) && !clr;
    memWe   = (state_q == S_WRITE);
  end

  assign memAddr = addr_q;
  assign memData = data_q;
  assign err     = err_q;
  assign errCode = code_q;
  assign full    = full_q;
  assign count   = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a 4-word memory: encodings, range errors,
// full handling, back-pressure, clear during a write and reset mid-write.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [2:0]    op = 3'd0;
  logic [4:0]    rd = 5'd0;
  logic [4:0]    rs1 = 5'd0;
  logic [4:0]    rs2 = 5'd0;
  logic [31:0]   imme = 32'h0;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [31:0]   memData;
  logic          memReady = 1'b1;
  logic          clr = 1'b0;
  logic          err;
  logic [1:0]    errCode;
  logic          full;
  logic [AW:0]   count;

  int checks = 0;
  int failures = 0;
  int lat = 0;
  logic [31:0] seen_data = 32'h0;

  instr_encoder #(.DEPTH(DEPTH), .BASE(0)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .inValid  (inValid),
    .inReady  (inReady),
    .op       (op),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .imme     (imme),
    .memWe    (memWe),
    .memAddr  (memAddr),
    .memData  (memData),
    .memReady (memReady),
    .clr      (clr),
    .err      (err),
    .errCode  (errCode),
    .full     (full),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Decoder view of the beq halfword immediate, rebuilt from the instruction word.
  function automatic logic [31:0] dec_beq_imm(input logic [31:0] w);
    return {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
  endfunction

  task automatic issue(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im);
    int n;
    logic taken;
    taken = 1'b0;
    @(negedge clk);
    op = o; rd = d; rs1 = s1; rs2 = s2; imme = im;
    inValid = 1'b1;
    n = 0;
    while (!taken && n < 20) begin
      if (inReady) begin
        @(posedge clk);
        taken = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    #1 inValid = 1'b0;
    if (!taken) check_val("accept_timeout", 32'(taken), 32'd1);
  endtask

  // Waits for memWe; if memReady is high, returns just after the completing edge.
  task automatic expect_write(input string tag, input logic [31:0] exp_data, input logic [AW-1:0] exp_addr);
    int n;
    logic hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < 10) begin
      @(negedge clk);
      n++;
      if (memWe) hit = 1'b1;
    end
    check_val({tag, "_we"}, 32'(hit), 32'd1);
    if (hit) begin
      lat = n;
      seen_data = memData;
      check_val({tag, "_data"}, memData, exp_data);
      check_val({tag, "_addr"}, 32'(memAddr), 32'(exp_addr));
      if (memReady) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #12;
    check_val("rst_inReady", 32'(inReady), 32'd0);
    check_val("rst_memWe",   32'(memWe),   32'd0);
    check_val("rst_memAddr", 32'(memAddr), 32'd0);
    check_val("rst_memData", memData,      32'd0);
    check_val("rst_err",     {31'd0, err, errCode}, 32'd0);
    check_val("rst_full",    32'(full),    32'd0);
    check_val("rst_count",   32'(count),   32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1 check_val("rel_inReady_low", 32'(inReady), 32'd0);
    @(posedge clk);
    #1 check_val("rel_inReady_high", 32'(inReady), 32'd1);

    // addi x1, x0, 5
    issue(3'd3, 5'd1, 5'd0, 5'd0, 32'd5);
    expect_write("addi", 32'h0050_0093, 2'd0);
    check_val("addi_latency", 32'(lat), 32'd2);
    check_val("addi_count", 32'(count), 32'd1);

    // beq x1, x2, -2 halfwords
    issue(3'd4, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFE);
    expect_write("beq", 32'hFE20_8EE3, 2'd1);
    check_val("beq_dec_imm", dec_beq_imm(seen_data), 32'hFFFF_FFFE);
    check_val("beq_count", 32'(count), 32'd2);

    // jal at the top of its range, then one past it
    issue(3'd5, 5'd1, 5'd0, 5'd0, 32'h0007_FFFF);
    expect_write("jal_max", 32'h7FFF_F0EF, 2'd2);
    issue(3'd5, 5'd1, 5'd0, 5'd0, 32'h0008_0000);
    repeat (4) begin
      @(negedge clk);
      check_val("jal_ovf_no_we", 32'(memWe), 32'd0);
    end
    check_val("jal_ovf_err",  32'(err),     32'd1);
    check_val("jal_ovf_code", 32'(errCode), 32'd2);
    check_val("jal_ovf_count", 32'(count),  32'd3);

    // illegal op with an out-of-range immediate: illegal wins; err does not block accept
    issue(3'd7, 5'd0, 5'd0, 5'd0, 32'd4096);
    repeat (3) @(negedge clk);
    check_val("op7_err",  32'(err),     32'd1);
    check_val("op7_code", 32'(errCode), 32'd1);
    check_val("op7_no_we", 32'(memWe),  32'd0);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    check_val("clr_err",   {31'd0, err, errCode}, 32'd0);
    check_val("clr_addr",  32'(memAddr), 32'd0);
    check_val("clr_count", 32'(count),   32'd0);

    // fill all four words
    issue(3'd0, 5'd2, 5'd3, 5'd0, 32'hFFFF_FFFC);
    expect_write("lw", 32'hFFC1_A103, 2'd0);
    issue(3'd1, 5'd0, 5'd2, 5'd5, 32'd8);
    expect_write("sw", 32'h0051_2423, 2'd1);
    issue(3'd2, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF);
    expect_write("add", 32'h0020_81B3, 2'd2);
    issue(3'd3, 5'd1, 5'd0, 5'd0, 32'd5);
    expect_write("addi_last", 32'h0050_0093, 2'd3);
    check_val("full_flag",    32'(full),    32'd1);
    check_val("full_inReady", 32'(inReady), 32'd0);
    check_val("full_count",   32'(count),   32'd4);
    check_val("full_addr",    32'(memAddr), 32'd3);
    @(negedge clk);
    op = 3'd2; inValid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_val("full_ignore_we", {31'd0, memWe, inReady}, 32'd0);
    end
    inValid = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    check_val("full_clr_full",  32'(full),    32'd0);
    check_val("full_clr_count", 32'(count),   32'd0);
    check_val("full_clr_addr",  32'(memAddr), 32'd0);
    @(negedge clk);
    check_val("full_clr_ready", 32'(inReady), 32'd1);

    // back-pressure: memReady low for five cycles
    memReady = 1'b0;
    issue(3'd2, 5'd3, 5'd1, 5'd2, 32'h0);
    expect_write("stall", 32'h0020_81B3, 2'd0);
    repeat (5) begin
      @(negedge clk);
      check_val("stall_hold", {memData[31:1], memWe}, {32'h0020_81B2 | 32'd1});
    end
    memReady = 1'b1;
    @(posedge clk);
    #1;
    check_val("stall_count", 32'(count), 32'd1);
    check_val("stall_we_off", 32'(memWe), 32'd0);

    // reset asserted mid-write aborts it asynchronously
    memReady = 1'b0;
    issue(3'd3, 5'd4, 5'd4, 5'd0, 32'd1);
    expect_write("abort", 32'h0012_0213, 2'd1);
    #2 rstn = 1'b0;
    #1;
    check_val("abort_we",    32'(memWe),   32'd0);
    check_val("abort_count", 32'(count),   32'd0);
    check_val("abort_addr",  32'(memAddr), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    memReady = 1'b1;
    #1 check_val("abort_rel_ready", 32'(inReady), 32'd0);
    @(posedge clk);
    #1 check_val("abort_ready_up", 32'(inReady), 32'd1);

    // clear raised during a stalled write: the write still lands, then the clear applies
    issue(3'd2, 5'd3, 5'd1, 5'd2, 32'h0);
    expect_write("pre_clr", 32'h0020_81B3, 2'd0);
    check_val("pre_clr_count", 32'(count), 32'd1);
    memReady = 1'b0;
    issue(3'd1, 5'd0, 5'd2, 5'd5, 32'd8);
    expect_write("wclr", 32'h0051_2423, 2'd1);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    check_val("wclr_pending_we", 32'(memWe), 32'd1);
    check_val("wclr_pending_addr", 32'(memAddr), 32'd1);
    @(negedge clk);
    memReady = 1'b1;
    @(posedge clk);
    #1;
    check_val("wclr_we_off", 32'(memWe),   32'd0);
    check_val("wclr_count",  32'(count),   32'd0);
    check_val("wclr_addr",   32'(memAddr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
